axi4_lite_csr_master: RTL

- AXI4-Lite initiator that turns a simple single-beat command stream into register writes and reads on an axi4_lite_if.
- Drives CSR slaves in the img_proc blocks, e.g. the filter enable registers, from a local sequencer, UART bridge or testbench-free bring-up logic.
- One transaction outstanding at a time; each command produces exactly one response beat.

---
 rtl/axi4_lite_csr_master_if.sv | 36 +++
 rtl/axi4_lite_csr_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_csr_master_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) shared by the CSR initiator and its slaves.
interface axi4_lite_if #(
    parameter int ADDR_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_csr_master.sv
// Single-outstanding AXI4-Lite initiator turning a command stream into CSR reads/writes.
// Define AXI4_LITE_MASTER_TIMEOUT_EN to bound every AXI wait state by TIMEOUT_CYCLES.
module axi4_lite_csr_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_wr_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        rsp_resp_o,
    output logic              busy_o,
    output logic [2:0]        dbg_state_o,
    axi4_lite_if.master       csr_o
);
    // Handshakes (cmd, rsp, and every AXI channel): a beat transfers on the rising
    // clock edge where valid && ready; valid never depends on ready, payload is held while valid.
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
    } state_e;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_e            state_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              rsp_valid_q, rsp_wr_q;
    logic [31:0]       rsp_rdata_q;
    logic [1:0]        rsp_resp_q;
    logic              aw_done, w_done;

    // A channel is finished once its valid is already low or handshakes this cycle.
    assign aw_done = !awvalid_q || csr_o.awready;
    assign w_done  = !wvalid_q  || csr_o.wready;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_flag_q;
    logic             tmo_hit;
    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
`endif
        end else begin
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
            // Free-running; cleared on every entry into a wait state.
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_wr_i) begin
                            awaddr_q  <= cmd_addr_i;
                            wdata_q   <= cmd_wdata_i;
                            wstrb_q   <= cmd_wstrb_i;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr_i;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_REQ;
                        end
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                S_WR_REQ: begin
                    if (csr_o.awready) awvalid_q <= 1'b0;
                    if (csr_o.wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
                        tmo_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= 2'b11;
                        tmo_flag_q  <= 1'b1;
                        state_q     <= S_RSP;
`endif
                    end
                end
                S_WR_RESP: begin
                    if (csr_o.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= csr_o.bresp;
                        state_q     <= S_RSP;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= 2'b11;
                        tmo_flag_q  <= 1'b1;
                        state_q     <= S_RSP;
`endif
                    end
                end
                S_RD_REQ: begin
                    if (csr_o.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_RESP;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
                        tmo_cnt_q <= '0;
                    end else if (tmo_hit) begin
                        arvalid_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= 2'b11;
                        tmo_flag_q  <= 1'b1;
                        state_q     <= S_RSP;
`endif
                    end
                end
                S_RD_RESP: begin
                    if (csr_o.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b0;
                        rsp_rdata_q <= csr_o.rdata;
                        rsp_resp_q  <= csr_o.rresp;
                        state_q     <= S_RSP;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= 2'b11;
                        tmo_flag_q  <= 1'b1;
                        state_q     <= S_RSP;
`endif
                    end
                end
                S_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_wr_o      = rsp_wr_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_resp_o    = rsp_resp_q;

    assign csr_o.awvalid = awvalid_q;
    assign csr_o.awaddr  = awaddr_q;
    assign csr_o.awprot  = 3'b000;
    assign csr_o.wvalid  = wvalid_q;
    assign csr_o.wdata   = wdata_q;
    assign csr_o.wstrb   = wstrb_q;
    assign csr_o.bready  = bready_q;
    assign csr_o.arvalid = arvalid_q;
    assign csr_o.araddr  = araddr_q;
    assign csr_o.arprot  = 3'b000;
    assign csr_o.rready  = rready_q;
endmodule
